// File: rtl/cache_pkg.sv
// Shared definitions for the parametrised set-associative data cache.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package cache_pkg;

  // Controller states
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WB   = 2'd1;
  localparam logic [1:0] FILL = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  // Ceiling log2; returns 0 for a value of 1 so single-set caches get no index bits
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Bit position of word 'off' inside a packed line (word 0 in the low bits)
  function automatic int wordLsb(input int off, input int wordSize);
    return off * wordSize;
  endfunction

endpackage

// File: rtl/dcache_way_array.sv
// One way of the cache: tag/valid/dirty/data per set, async read, sync write.
// Latency: reads combinational from idx; writes land on the rising edge.
// Backpressure: none; the controller owns sequencing, a line write wins over a word write.
module dcache_way_array
  import cache_pkg::*;
#(
  parameter int WORD_SIZE   = 16,
  parameter int BLOCK_WORDS = 4,
  parameter int SETS        = 4,
  parameter int TAG_W       = 12,
  parameter int IDX_WS      = 2,
  parameter int OFF_W       = 2,
  parameter int LINE_W      = BLOCK_WORDS * WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [IDX_WS-1:0]    idx,
  output logic [TAG_W-1:0]     rdTag,
  output logic                 rdValid,
  output logic                 rdDirty,
  output logic [LINE_W-1:0]    rdLine,
  input  logic                 wordWe,
  input  logic [OFF_W-1:0]     wordOff,
  input  logic [WORD_SIZE-1:0] wordData,
  input  logic                 lineWe,
  input  logic [TAG_W-1:0]     lineTag,
  input  logic [LINE_W-1:0]    lineData
);

  logic [SETS-1:0]   valid;
  logic [SETS-1:0]   dirty;
  logic [TAG_W-1:0]  tags [SETS];
  logic [LINE_W-1:0] data [SETS];

  assign rdTag   = tags[idx];
  assign rdValid = valid[idx];
  assign rdDirty = dirty[idx];
  assign rdLine  = data[idx];

  // Status bits: a fill makes the line valid and clean, a word write dirties it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (lineWe) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (wordWe) begin
      dirty[idx] <= 1'b1;
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set
  always_ff @(posedge clk) begin
    if (lineWe) begin
      tags[idx] <= lineTag;
      data[idx] <= lineData;
    end else if (wordWe) begin
      data[idx][wordLsb(int'(wordOff), WORD_SIZE) +: WORD_SIZE] <= wordData;
    end
  end

endmodule

// File: rtl/param_assoc_dcache.sv
// Write-back, write-allocate set-associative data cache in front of a fixed-latency block memory.
// Latency: hit 0 cycles; miss MEM_LATENCY+1 (clean victim) or 2*MEM_LATENCY+1 (dirty victim).
// Backpressure: requester holds readC/writeC until ready; a dropped request still completes its fill.
// Optional PARAM_DCACHE_STATS_EN adds access_cnt/hit_cnt request counters.
module param_assoc_dcache
  import cache_pkg::*;
#(
  parameter int WORD_SIZE   = 16,
  parameter int BLOCK_WORDS = 4,
  parameter int SETS        = 4,
  parameter int WAYS        = 2,
  parameter int MEM_LATENCY = 4,
  localparam int LINE_W     = BLOCK_WORDS * WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 readC,
  input  logic                 writeC,
  input  logic [WORD_SIZE-1:0] addressC,
  input  logic [WORD_SIZE-1:0] wdataC,
  output logic [WORD_SIZE-1:0] rdataC,
  output logic                 ready,
  output logic                 cache_hit,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] addressM,
  output logic [LINE_W-1:0]    wdataM,
  input  logic [LINE_W-1:0]    rdataM
`ifdef PARAM_DCACHE_STATS_EN
  ,
  output logic [WORD_SIZE-1:0] access_cnt,
  output logic [WORD_SIZE-1:0] hit_cnt
`endif
);

  localparam int OFF_W  = clog2(BLOCK_WORDS);
  localparam int IDX_W  = clog2(SETS);
  localparam int IDX_WS = (IDX_W > 0) ? IDX_W : 1;
  localparam int TAG_W  = WORD_SIZE - IDX_W - OFF_W;
  localparam int CNT_W  = clog2(MEM_LATENCY) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LATENCY - 1);

  logic [1:0]           state;
  logic [CNT_W-1:0]     latCnt;
  logic [WORD_SIZE-1:0] reqAddr;
  logic                 victimWay;
  logic [WORD_SIZE-1:0] victimAddr;
  logic [LINE_W-1:0]    victimLine;

  logic                 req;
  logic [WORD_SIZE-1:0] curAddr;
  logic [TAG_W-1:0]     curTag;
  logic [IDX_WS-1:0]    curIdx;
  logic [OFF_W-1:0]     curOff;

  logic [TAG_W-1:0]     wayTag  [WAYS];
  logic [LINE_W-1:0]    wayLine [WAYS];
  logic [WAYS-1:0]      wayValid;
  logic [WAYS-1:0]      wayDirty;
  logic [WAYS-1:0]      hitVec;
  logic                 hit;
  logic                 hitWay;
  logic                 victimSel;
  logic                 selWay;
  logic [LINE_W-1:0]    selLine;
  logic                 wordWe;
  logic                 lineWe;
  logic                 touchEn;
  logic                 touchWay;

  assign req = readC | writeC;

  // While a miss is in flight the captured address selects the set, not the live port
  assign curAddr = (state == IDLE) ? addressC : reqAddr;
  assign curTag  = curAddr[WORD_SIZE-1 -: TAG_W];
  assign curOff  = curAddr[OFF_W-1:0];

  generate
    if (IDX_W > 0) begin : gIdx
      assign curIdx = curAddr[OFF_W +: IDX_W];
    end else begin : gNoIdx
      assign curIdx = '0;
    end
  endgenerate

  assign lineWe = (state == FILL) && (latCnt == LAST);

  generate
    for (genvar w = 0; w < WAYS; w++) begin : gWay
      dcache_way_array #(
        .WORD_SIZE(WORD_SIZE), .BLOCK_WORDS(BLOCK_WORDS), .SETS(SETS),
        .TAG_W(TAG_W), .IDX_WS(IDX_WS), .OFF_W(OFF_W), .LINE_W(LINE_W)
      ) uWay (
        .clk(clk),
        .reset_n(reset_n),
        .idx(curIdx),
        .rdTag(wayTag[w]),
        .rdValid(wayValid[w]),
        .rdDirty(wayDirty[w]),
        .rdLine(wayLine[w]),
        .wordWe(wordWe && (selWay == 1'(w))),
        .wordOff(curOff),
        .wordData(wdataC),
        .lineWe(lineWe && (victimWay == 1'(w))),
        .lineTag(curTag),
        .lineData(rdataM)
      );
    end
  endgenerate

  // Tag compare across all ways of the addressed set
  always_comb begin
    hitVec = '0;
    hitWay = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      hitVec[w] = wayValid[w] && (wayTag[w] == curTag);
      if (hitVec[w]) hitWay = 1'(w);
    end
  end

  assign hit       = |hitVec;
  assign ready     = ((state == IDLE) && req && hit) || (state == RESP);
  assign cache_hit = (state == IDLE) && req && hit;
  assign selWay    = (state == RESP) ? victimWay : hitWay;
  assign selLine   = wayLine[selWay];
  assign wordWe    = ready && writeC;
  assign rdataC    = (ready && readC) ? selLine[wordLsb(int'(curOff), WORD_SIZE) +: WORD_SIZE] : '0;

  assign touchEn   = cache_hit || (state == RESP);
  assign touchWay  = (state == RESP) ? victimWay : hitWay;

  assign readM     = (state == FILL);
  assign writeM    = (state == WB);
  assign addressM  = (state == WB)   ? victimAddr :
                     (state == FILL) ? {reqAddr[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign wdataM    = (state == WB) ? victimLine : '0;

  generate
    if (WAYS == 2) begin : gLru
      logic [SETS-1:0] lruWay;

      // Per set, remember the way to evict next: the one not touched most recently
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) lruWay <= '0;
        else if (touchEn) lruWay[curIdx] <= ~touchWay;
      end

      assign victimSel = !wayValid[0] ? 1'b0 :
                         !wayValid[1] ? 1'b1 : lruWay[curIdx];
    end else begin : gNoLru
      assign victimSel = 1'b0;
    end
  endgenerate

  // Miss controller: capture victim on the first miss cycle, then write back, fill, respond
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      latCnt     <= '0;
      reqAddr    <= '0;
      victimWay  <= 1'b0;
      victimAddr <= '0;
      victimLine <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            reqAddr    <= addressC;
            victimWay  <= victimSel;
            victimAddr <= (WORD_SIZE'(wayTag[victimSel]) << (IDX_W + OFF_W)) |
                          (WORD_SIZE'(curIdx) << OFF_W);
            victimLine <= wayLine[victimSel];
            latCnt     <= '0;
            state      <= (wayValid[victimSel] && wayDirty[victimSel]) ? WB : FILL;
          end
        end
        WB: begin
          if (latCnt == LAST) begin
            latCnt <= '0;
            state  <= FILL;
          end else begin
            latCnt <= latCnt + 1'b1;
          end
        end
        FILL: begin
          if (latCnt == LAST) state <= RESP;
          else latCnt <= latCnt + 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PARAM_DCACHE_STATS_EN
  // Count each completed request once, and the subset that hit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      access_cnt <= '0;
      hit_cnt    <= '0;
    end else if (ready && req) begin
      access_cnt <= access_cnt + 1'b1;
      if (cache_hit) hit_cnt <= hit_cnt + 1'b1;
    end
  end
`endif

endmodule
